// File: rtl/sdp_read_streamer.sv
// sdp_read_streamer: read-side sequencer for the simple dual-port RAM.
// Walks an address range, absorbs the RAM's one-cycle read latency and
// presents the returned words as a valid/ready stream with a last marker.
// Optional feature macro: STREAM_STRIDE_EN (adds the stride port; without it
// the address increment is fixed at 1).
//
// state | meaning
// IDLE  | waiting for start; zero-length start only pulses done
// RUN   | issuing reads, throttled by buffer occupancy
// DRAIN | all reads issued; waiting for the last word to be popped

module sdp_read_streamer #(
   parameter int ADDR_WIDTH  = 9,
   parameter int WORD_LENGTH = 40,
   parameter int LEN_WIDTH   = 10
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   start,
   input  logic [ADDR_WIDTH-1:0]  start_addr,
   input  logic [LEN_WIDTH-1:0]   length,
`ifdef STREAM_STRIDE_EN
   input  logic [ADDR_WIDTH-1:0]  stride,
`endif
   output logic                   busy,
   output logic                   done,
   output logic [ADDR_WIDTH-1:0]  ram_read_address,
   input  logic [WORD_LENGTH-1:0] ram_read_data,
   output logic [WORD_LENGTH-1:0] out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_last
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                 state, state_nxt;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [ADDR_WIDTH-1:0]  addr_inc;
   logic [LEN_WIDTH-1:0]   issue_cnt;
   logic                   inflight, inflight_last;
   logic [WORD_LENGTH-1:0] fifo_data [2];
   logic [1:0]             fifo_last;
   logic                   rd_ptr, wr_ptr;
   logic [1:0]             fifo_count;
   logic                   pop, issue, issue_last, start_run, start_zero;
   logic                   done_q;

`ifdef STREAM_STRIDE_EN
   logic [ADDR_WIDTH-1:0]  stride_q;

   // Stride is latched with the command so it stays stable for the transfer.
   always_ff @(posedge clk) begin
      if (!resetn)
         stride_q <= '0;
      else if (start_run)
         stride_q <= stride;
   end

   assign addr_inc = stride_q;
`else
   assign addr_inc = ADDR_WIDTH'(1);
`endif

   // Issue throttle: words already buffered or in flight, less the one leaving
   // this cycle, must leave room for the read issued now. out_ready feeds this
   // combinationally so issue resumes in the very cycle the stall releases.
   always_comb begin
      pop        = (fifo_count != 2'd0) && out_ready;
      start_run  = (state == IDLE) && start && (length != '0);
      start_zero = (state == IDLE) && start && (length == '0);
      issue      = (state == RUN) &&
                   (({1'b0, fifo_count} + {2'b00, inflight}) <= (3'd1 + {2'b00, pop}));
      issue_last = issue && (issue_cnt == LEN_WIDTH'(1));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!resetn)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_run) state_nxt = RUN;
         RUN:     if (issue_last) state_nxt = DRAIN;
         DRAIN:   if (pop && out_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Address generator and issue counter; inflight marks a read whose data
   // arrives on ram_read_data this cycle.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         addr_q        <= '0;
         issue_cnt     <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         if (start_run) begin
            addr_q    <= start_addr;
            issue_cnt <= length;
         end else if (issue) begin
            addr_q    <= addr_q + addr_inc;
            issue_cnt <= issue_cnt - LEN_WIDTH'(1);
         end
         inflight      <= issue;
         inflight_last <= issue_last;
      end
   end

   // Two-entry output buffer; push and pop may coincide.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         fifo_data[0] <= '0;
         fifo_data[1] <= '0;
         fifo_last    <= 2'b00;
         rd_ptr       <= 1'b0;
         wr_ptr       <= 1'b0;
         fifo_count   <= 2'd0;
      end else begin
         if (inflight) begin
            fifo_data[wr_ptr] <= ram_read_data;
            fifo_last[wr_ptr] <= inflight_last;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
      end
   end

   // done is registered: one cycle after the final pop or a zero-length start.
   always_ff @(posedge clk) begin
      if (!resetn)
         done_q <= 1'b0;
      else
         done_q <= start_zero || ((state == DRAIN) && pop && out_last);
   end

   assign busy             = (state != IDLE);
   assign done             = done_q;
   assign ram_read_address = addr_q;
   assign out_valid        = (fifo_count != 2'd0);
   assign out_data         = fifo_data[rd_ptr];
   assign out_last         = out_valid && fifo_last[rd_ptr];

endmodule

// File: tb/tb_sdp_read_streamer.sv
// Testbench for sdp_read_streamer: behavioural registered-read RAM plus a
// scoreboard queue filled at command time and drained on each stream pop.

module tb_sdp_read_streamer;

   localparam int AW = 9;
   localparam int DW = 40;
   localparam int LW = 10;

   logic          clk = 1'b0;
   logic          resetn;
   logic          start;
   logic [AW-1:0] start_addr;
   logic [LW-1:0] length;
   logic [AW-1:0] stride;
   logic          busy, done;
   logic [AW-1:0] ram_read_address;
   logic [DW-1:0] ram_read_data;
   logic [DW-1:0] out_data;
   logic          out_valid, out_ready, out_last;

   logic [DW-1:0] ram [1 << AW];
   logic [DW:0]   sb [$];

   int n_cmp = 0;
   int n_bad = 0;
   int pops  = 0;
   bit bp_mode = 0;
   logic [AW-1:0] bp_base;

   always #5 clk = ~clk;

   sdp_read_streamer #(.ADDR_WIDTH(AW), .WORD_LENGTH(DW), .LEN_WIDTH(LW)) dut (
      .clk              (clk),
      .resetn           (resetn),
      .start            (start),
      .start_addr       (start_addr),
      .length           (length),
`ifdef STREAM_STRIDE_EN
      .stride           (stride),
`endif
      .busy             (busy),
      .done             (done),
      .ram_read_address (ram_read_address),
      .ram_read_data    (ram_read_data),
      .out_data         (out_data),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_last         (out_last)
   );

   // Registered-read RAM model.
   always @(posedge clk) ram_read_data <= ram[ram_read_address];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Stream monitor: every pop is compared against the scoreboard head.
   always @(negedge clk) begin
      if (resetn === 1'b1 && out_valid && out_ready) begin
         if (bp_mode)
            chk("addr_ahead", 64'((AW'(ram_read_address - bp_base)) > pops + 2), 64'd0);
         if (sb.size() == 0) begin
            chk("spurious_pop", 64'd1, 64'd0);
         end else begin
            logic [DW:0] e;
            e = sb.pop_front();
            chk("data", 64'(out_data), 64'(e[DW-1:0]));
            chk("last", 64'(out_last), 64'(e[DW]));
         end
         pops++;
      end
   end

   task automatic start_xfer(input logic [AW-1:0] a, input logic [LW-1:0] n,
                             input logic [AW-1:0] s, input bit expect_it);
      logic [AW-1:0] ad;
      logic [AW-1:0] inc;
`ifdef STREAM_STRIDE_EN
      inc = s;
`else
      inc = AW'(1);
`endif
      @(posedge clk); #1;
      start = 1'b1; start_addr = a; length = n; stride = s;
      if (expect_it) begin
         ad = a;
         for (int i = 0; i < int'(n); i++) begin
            sb.push_back({(i == int'(n) - 1), ram[ad]});
            ad = ad + inc;
         end
      end
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      bit seen;
      seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      chk(tag, 64'(seen), 64'd1);
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) ram[i] = DW'(i);
      resetn = 1'b0; start = 1'b0; start_addr = '0; length = '0; stride = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_last", 64'(out_last), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_addr", 64'(ram_read_address), 64'd0);
      @(posedge clk); #1 resetn = 1'b1;

      // Basic transfer with cycle-exact timing.
      start_xfer(9'h010, 10'd4, 9'd1, 1);
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         chk($sformatf("basic_busy_c%0d", c), 64'(busy), 64'(c <= 6));
         chk($sformatf("basic_valid_c%0d", c), 64'(out_valid), 64'(c >= 3 && c <= 6));
         chk($sformatf("basic_last_c%0d", c), 64'(out_last), 64'(c == 6));
         chk($sformatf("basic_done_c%0d", c), 64'(done), 64'(c == 7));
      end
      chk("basic_sb_empty", 64'(sb.size()), 64'd0);

      // Address wrap-around.
      start_xfer(9'h1FE, 10'd4, 9'd1, 1);
      wait_done(30, "wrap_done");
      chk("wrap_sb_empty", 64'(sb.size()), 64'd0);

      // Backpressure with random out_ready.
      bp_base = 9'h020;
      pops = 0;
      bp_mode = 1;
      start_xfer(9'h020, 10'd8, 9'd1, 1);
      begin
         bit seen;
         seen = 0;
         for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
         end
         chk("bp_done", 64'(seen), 64'd1);
      end
      bp_mode = 0;
      out_ready = 1'b1;
      chk("bp_sb_empty", 64'(sb.size()), 64'd0);
      chk("bp_pops", 64'(pops), 64'd8);

      // Zero length: done next cycle, no stream output.
      start_xfer(9'h033, 10'd0, 9'd1, 1);
      @(negedge clk);
      chk("zero_done", 64'(done), 64'd1);
      chk("zero_busy", 64'(busy), 64'd0);
      chk("zero_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      chk("zero_done_pulse", 64'(done), 64'd0);
      chk("zero_valid2", 64'(out_valid), 64'd0);

      // Start while busy is ignored.
      start_xfer(9'h040, 10'd4, 9'd1, 1);
      start_xfer(9'h100, 10'd3, 9'd1, 0);
      wait_done(30, "busy_done");
      repeat (4) @(negedge clk);
      chk("busy_ignored_idle", 64'(busy), 64'd0);
      chk("busy_sb_empty", 64'(sb.size()), 64'd0);

      // Reset mid-transfer at word 3 of 8.
      pops = 0;
      start_xfer(9'h080, 10'd8, 9'd1, 1);
      for (int i = 0; i < 40 && pops < 3; i++) @(negedge clk);
      chk("mid_reached_w3", 64'(pops >= 3), 64'd1);
      @(posedge clk); #1;
      resetn = 1'b0;
      sb.delete();
      @(posedge clk); #1;
      resetn = 1'b1;
      @(negedge clk);
      chk("mid_busy", 64'(busy), 64'd0);
      chk("mid_done", 64'(done), 64'd0);
      chk("mid_valid", 64'(out_valid), 64'd0);
      chk("mid_last", 64'(out_last), 64'd0);
      chk("mid_data", 64'(out_data), 64'd0);
      chk("mid_addr", 64'(ram_read_address), 64'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("mid_no_done", 64'(done), 64'd0);
         chk("mid_no_valid", 64'(out_valid), 64'd0);
      end
      start_xfer(9'h0C0, 10'd2, 9'd1, 1);
      wait_done(30, "mid_restart_done");
      chk("mid_sb_empty", 64'(sb.size()), 64'd0);

`ifdef STREAM_STRIDE_EN
      start_xfer(9'h000, 10'd4, 9'd3, 1);
      wait_done(30, "stride_done");
      chk("stride_sb_empty", 64'(sb.size()), 64'd0);
`endif

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
